// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand-pair buffer and sequencer feeding the 8x8 MAC
//
// Buffers up to DEPTH (a,b) byte pairs while IDLE. On start, it streams them to
// the MAC one per cycle with mac_en high. It then holds mac_en high for
// DRAIN_CYCLES cycles with zero operands, drops mac_en and pulses done.
// DRAIN_CYCLES must be at least 1.
//
// Optional feature macro: MAC_FEEDER_REPLAY_EN
//   defined     : buffer and count survive DONE, so a later start replays the pairs
//   not defined : buffer is consumed (count and wr_ptr cleared in the DONE cycle)
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   clear             empty the buffer (IDLE only, wins over start)
//   in_valid/in_a/in_b/in_ready   pair load handshake
//   start             begin streaming the buffered pairs
//   busy, done        RUN/DRAIN indicator, one-cycle completion pulse
//   count             pairs currently buffered
//   mac_en/mac_a/mac_b   registered operand stream to the MAC
module mac_operand_feeder #(
   parameter  int DEPTH        = 8,
   parameter  int DRAIN_CYCLES = 2,
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [7:0]    in_a,
   input  logic [7:0]    in_b,
   output logic          in_ready,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count,
   output logic          mac_en,
   output logic [7:0]    mac_a,
   output logic [7:0]    mac_b
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] pairs_left_q, pairs_left_d;
   logic [DW-1:0] drain_left_q, drain_left_d;
   logic [7:0]    buf_a_q [DEPTH];
   logic [7:0]    buf_a_d [DEPTH];
   logic [7:0]    buf_b_q [DEPTH];
   logic [7:0]    buf_b_d [DEPTH];
   logic          mac_en_q, mac_en_d;
   logic [7:0]    mac_a_q, mac_a_d;
   logic [7:0]    mac_b_q, mac_b_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [PW-1:0] rd_sel;
   logic          load;

   assign in_ready = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !start && !clear;
   assign load     = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         pairs_left_q <= '0;
         drain_left_q <= '0;
         mac_en_q     <= 1'b0;
         mac_a_q      <= '0;
         mac_b_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pairs_left_q <= pairs_left_d;
         drain_left_q <= drain_left_d;
         mac_en_q     <= mac_en_d;
         mac_a_q      <= mac_a_d;
         mac_b_q      <= mac_b_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Pair storage carries no reset; count decides which entries are meaningful.
   always_ff @(posedge clk) begin
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      pairs_left_d = pairs_left_q;
      drain_left_d = drain_left_q;
      buf_a_d      = buf_a_q;
      buf_b_d      = buf_b_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               count_d  = '0;
               wr_ptr_d = '0;
            end else if (start && (count_q != '0)) begin
               // Pair 0 is presented on the transition edge, so rd_ptr already
               // points at pair 1 and pairs_left counts the pairs after it.
               state_d      = RUN;
               rd_ptr_d     = PW'(1);
               pairs_left_d = count_q - 1'b1;
            end else if (load) begin
               buf_a_d[wr_ptr_q] = in_a;
               buf_b_d[wr_ptr_q] = in_b;
               wr_ptr_d          = wr_ptr_q + 1'b1;
               count_d           = count_q + 1'b1;
            end
         end
         RUN: begin
            if (pairs_left_q == '0) begin
               state_d      = DRAIN;
               drain_left_d = DW'(DRAIN_CYCLES - 1);
            end else begin
               rd_ptr_d     = rd_ptr_q + 1'b1;
               pairs_left_d = pairs_left_q - 1'b1;
            end
         end
         DRAIN: begin
            if (drain_left_q == '0) begin
               state_d = DONE;
`ifndef MAC_FEEDER_REPLAY_EN
               count_d  = '0;
               wr_ptr_d = '0;
`endif
            end else begin
               drain_left_d = drain_left_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: registered outputs follow the state being entered.
   assign rd_sel = (state_q == IDLE) ? '0 : rd_ptr_q;

   always_comb begin
      mac_en_d = 1'b0;
      mac_a_d  = '0;
      mac_b_d  = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         RUN: begin
            mac_en_d = 1'b1;
            busy_d   = 1'b1;
            mac_a_d  = buf_a_q[rd_sel];
            mac_b_d  = buf_b_q[rd_sel];
         end
         DRAIN: begin
            mac_en_d = 1'b1;
            busy_d   = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            mac_en_d = 1'b0;
         end
      endcase
   end

   assign count  = count_q;
   assign mac_en = mac_en_q;
   assign mac_a  = mac_a_q;
   assign mac_b  = mac_b_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed self-checking bench for mac_operand_feeder
module tb_mac_operand_feeder;

   localparam int DEPTH = 8;
   localparam int DRAIN = 2;
`ifdef MAC_FEEDER_REPLAY_EN
   localparam bit REPLAY = 1'b1;
`else
   localparam bit REPLAY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear;
   logic       in_valid;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_ready;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] count;
   logic       mac_en;
   logic [7:0] mac_a;
   logic [7:0] mac_b;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int acc;
   logic [7:0] exp_a [16];
   logic [7:0] exp_b [16];

   always #5 clk = ~clk;

   mac_operand_feeder #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_ready (in_ready),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .mac_en   (mac_en),
      .mac_a    (mac_a),
      .mac_b    (mac_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_buf();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Called in the first cycle after the start edge; checks n pairs, the drain
   // cycles and the done pulse, accumulating the MAC product sum.
   task automatic check_stream(input int n, input string tag);
      acc = 0;
      for (int k = 0; k < n; k++) begin
         check({tag, "_pair"}, {15'd0, mac_en, mac_a, mac_b}, {15'd0, 1'b1, exp_a[k], exp_b[k]});
         acc += int'(mac_a) * int'(mac_b);
         tick();
      end
      for (int d = 0; d < DRAIN; d++) begin
         check({tag, "_drain"}, {29'd0, mac_en, busy, 1'b0}, {29'd0, 1'b1, 1'b1, 1'b0});
         check({tag, "_drain_ops"}, {16'd0, mac_a, mac_b}, 32'd0);
         tick();
      end
      check({tag, "_done"}, {29'd0, done, busy, mac_en}, {29'd0, 1'b1, 1'b0, 1'b0});
      tick();
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      start    = 1'b0;
      tick();
      tick();
      check("rst_outs", {28'd0, busy, done, mac_en, in_ready}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_ops", {16'd0, mac_a, mac_b}, 32'd0);
      reset_n = 1'b1;
      tick();

      // 1: three pairs, product sum 68
      load(8'd2, 8'd3);
      load(8'd4, 8'd5);
      load(8'd6, 8'd7);
      check("t1_count", {28'd0, count}, 32'd3);
      exp_a[0] = 8'd2; exp_b[0] = 8'd3;
      exp_a[1] = 8'd4; exp_b[1] = 8'd5;
      exp_a[2] = 8'd6; exp_b[2] = 8'd7;
      start_pulse();
      check_stream(3, "t1");
      check("t1_acc", acc, 32'd68);
      check("t1_count_after", {28'd0, count}, REPLAY ? 32'd3 : 32'd0);
      clear_buf();

      // 2: nine back-to-back loads into an 8-deep buffer
      in_valid = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         in_a = 8'(i);
         in_b = 8'(i + 16);
         #1;
         if (i == 9) check("t2_ready_full", {31'd0, in_ready}, 32'd0);
         else if (i == 1) check("t2_ready_first", {31'd0, in_ready}, 32'd1);
         if (i <= 8) begin
            exp_a[i-1] = 8'(i);
            exp_b[i-1] = 8'(i + 16);
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("t2_count_full", {28'd0, count}, 32'd8);
      check("t2_ready_idle_full", {31'd0, in_ready}, 32'd0);
      start_pulse();
      check_stream(8, "t2");
      clear_buf();

      // 3: start with an empty buffer does nothing
      start_pulse();
      for (int c = 0; c < 10; c++) begin
         check("t3_idle", {29'd0, busy, mac_en, done}, 32'd0);
         tick();
      end

      // 4: reset in the middle of a run
      load(8'd10, 8'd1);
      load(8'd20, 8'd2);
      load(8'd30, 8'd3);
      load(8'd40, 8'd4);
      start_pulse();
      tick();
      check("t4_pair2", {16'd0, mac_a, mac_b}, {16'd0, 8'd20, 8'd2});
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("t4_after_rst", {28'd0, busy, mac_en, done, in_ready}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      check("t4_count_rst", {28'd0, count}, 32'd0);
      check("t4_ops_rst", {16'd0, mac_a, mac_b}, 32'd0);
      tick();
      load(8'd5, 8'd6);
      exp_a[0] = 8'd5; exp_b[0] = 8'd6;
      start_pulse();
      check_stream(1, "t4");
      check("t4_acc", acc, 32'd30);
      clear_buf();

      // 5: load coincident with start is rejected; clear beats start
      load(8'd7, 8'd8);
      load(8'd9, 8'd10);
      exp_a[0] = 8'd7; exp_b[0] = 8'd8;
      exp_a[1] = 8'd9; exp_b[1] = 8'd10;
      in_valid = 1'b1;
      in_a     = 8'd99;
      in_b     = 8'd99;
      start    = 1'b1;
      #1;
      check("t5_ready_start", {31'd0, in_ready}, 32'd0);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      check_stream(2, "t5");
      check("t5_count_after", {28'd0, count}, REPLAY ? 32'd2 : 32'd0);
      clear_buf();
      load(8'd1, 8'd2);
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      check("t5_clr_count", {28'd0, count}, 32'd0);
      check("t5_clr_norun", {30'd0, busy, mac_en}, 32'd0);
      tick();
      check("t5_clr_norun2", {30'd0, busy, mac_en}, 32'd0);

      // 6: second start replays only when the buffer is retained
      load(8'd1, 8'd1);
      load(8'd2, 8'd2);
      exp_a[0] = 8'd1; exp_b[0] = 8'd1;
      exp_a[1] = 8'd2; exp_b[1] = 8'd2;
      start_pulse();
      check_stream(2, "t6a");
      check("t6a_count", {28'd0, count}, REPLAY ? 32'd2 : 32'd0);
      start_pulse();
      if (REPLAY) begin
         check_stream(2, "t6b");
         check("t6b_count", {28'd0, count}, 32'd2);
      end else begin
         for (int c = 0; c < 5; c++) begin
            check("t6b_ignored", {29'd0, busy, mac_en, done}, 32'd0);
            tick();
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
